// File: rtl/wake_scheduler.sv
// Pending-table wake scheduler: tracks issued destinations and broadcasts them on four registered wake channels.
// Optional WAKE_BYPASS_EN: zero-latency issues broadcast directly on channels left free by the table.
module wake_scheduler #(
  parameter int DEPTH = 8,
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             Iss0_valid,
  input  logic [5:0]       Iss0_Phydst,
  input  logic [LAT_W-1:0] Iss0_Lat,
  input  logic             Iss1_valid,
  input  logic [5:0]       Iss1_Phydst,
  input  logic [LAT_W-1:0] Iss1_Lat,
  output logic             Full,
  output logic [4:0]       Pending_cnt,
  output logic             Err,
  output logic             Wake0,
  output logic [5:0]       Wake0_Phydst,
  output logic             Wake1,
  output logic [5:0]       Wake1_Phydst,
  output logic             Wake2,
  output logic [5:0]       Wake2_Phydst,
  output logic             Wake3,
  output logic [5:0]       Wake3_Phydst
);

  logic [DEPTH-1:0] valid_q;
  logic [5:0]       tag_q [DEPTH];
  logic [LAT_W-1:0] cnt_q [DEPTH];
  logic             err_q;

  logic [3:0]       wake_q;
  logic [5:0]       wtag_q [4];
  logic [3:0]       wake_d;
  logic [5:0]       wtag_d [4];

  logic [DEPTH-1:0] sel_mask;
  logic [DEPTH-1:0] free0_oh, free1_oh;
  logic [DEPTH-1:0] alloc0_oh, alloc1_oh;
  logic             f0, f1;
  logic             byp0, byp1;
  logic             need0, need1;
  logic             drop;
  logic [2:0]       nsel;
  logic [4:0]       pop;

  // Channel assignment: eligible table entries in index order, then bypassed issues.
  always_comb begin
    sel_mask = '0;
    wake_d   = '0;
    nsel     = '0;
    byp0     = 1'b0;
    byp1     = 1'b0;
    for (int unsigned k = 0; k < 4; k++) wtag_d[k] = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (cnt_q[i] == '0) && (nsel < 3'd4)) begin
        sel_mask[i]         = 1'b1;
        wake_d[nsel[1:0]]   = 1'b1;
        wtag_d[nsel[1:0]]   = tag_q[i];
        nsel                = nsel + 3'd1;
      end
    end
`ifdef WAKE_BYPASS_EN
    if (Iss0_valid && (Iss0_Phydst != '0) && (Iss0_Lat == '0) && (nsel < 3'd4)) begin
      byp0              = 1'b1;
      wake_d[nsel[1:0]] = 1'b1;
      wtag_d[nsel[1:0]] = Iss0_Phydst;
      nsel              = nsel + 3'd1;
    end
    if (Iss1_valid && (Iss1_Phydst != '0) && (Iss1_Lat == '0) && (nsel < 3'd4)) begin
      byp1              = 1'b1;
      wake_d[nsel[1:0]] = 1'b1;
      wtag_d[nsel[1:0]] = Iss1_Phydst;
      nsel              = nsel + 3'd1;
    end
`endif
  end

  // Free slots come from pre-edge valid bits only, so a slot freed by selection is not reused this edge.
  always_comb begin
    f0       = 1'b0;
    f1       = 1'b0;
    free0_oh = '0;
    free1_oh = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i]) begin
        if (!f0) begin
          f0          = 1'b1;
          free0_oh[i] = 1'b1;
        end else if (!f1) begin
          f1          = 1'b1;
          free1_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    need0     = Iss0_valid && (Iss0_Phydst != '0) && !byp0;
    need1     = Iss1_valid && (Iss1_Phydst != '0) && !byp1;
    alloc0_oh = need0 ? free0_oh : '0;
    alloc1_oh = need1 ? (need0 ? free1_oh : free0_oh) : '0;
    drop      = (need0 && !f0) || (need1 && !(need0 ? f1 : f0));
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < DEPTH; i++) pop = pop + 5'(valid_q[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      if (!flush && drop) err_q <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (flush) begin
          valid_q[i] <= 1'b0;
        end else if (alloc0_oh[i]) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= Iss0_Phydst;
          cnt_q[i]   <= Iss0_Lat;
        end else if (alloc1_oh[i]) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= Iss1_Phydst;
          cnt_q[i]   <= Iss1_Lat;
        end else if (sel_mask[i]) begin
          valid_q[i] <= 1'b0;
        end else if (valid_q[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wake_q <= '0;
      for (int unsigned k = 0; k < 4; k++) wtag_q[k] <= '0;
    end else if (flush) begin
      wake_q <= '0;
      for (int unsigned k = 0; k < 4; k++) wtag_q[k] <= '0;
    end else begin
      wake_q <= wake_d;
      for (int unsigned k = 0; k < 4; k++) wtag_q[k] <= wtag_d[k];
    end
  end

  assign Full         = (int'(pop) > DEPTH - 2);
  assign Pending_cnt  = pop;
  assign Err          = err_q;
  assign Wake0        = wake_q[0];
  assign Wake1        = wake_q[1];
  assign Wake2        = wake_q[2];
  assign Wake3        = wake_q[3];
  assign Wake0_Phydst = wtag_q[0];
  assign Wake1_Phydst = wtag_q[1];
  assign Wake2_Phydst = wtag_q[2];
  assign Wake3_Phydst = wtag_q[3];

endmodule

// File: tb/tb_wake_scheduler.sv
// Directed self-checking bench for wake_scheduler (DEPTH=8, LAT_W=4).
module tb_wake_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       Iss0_valid = 1'b0, Iss1_valid = 1'b0;
  logic [5:0] Iss0_Phydst = '0, Iss1_Phydst = '0;
  logic [3:0] Iss0_Lat = '0, Iss1_Lat = '0;
  logic       Full, Err;
  logic [4:0] Pending_cnt;
  logic       Wake0, Wake1, Wake2, Wake3;
  logic [5:0] Wake0_Phydst, Wake1_Phydst, Wake2_Phydst, Wake3_Phydst;

  logic [10:0] st;
  logic [23:0] tv;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wake_scheduler #(.DEPTH(8), .LAT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .Iss0_valid(Iss0_valid), .Iss0_Phydst(Iss0_Phydst), .Iss0_Lat(Iss0_Lat),
    .Iss1_valid(Iss1_valid), .Iss1_Phydst(Iss1_Phydst), .Iss1_Lat(Iss1_Lat),
    .Full(Full), .Pending_cnt(Pending_cnt), .Err(Err),
    .Wake0(Wake0), .Wake0_Phydst(Wake0_Phydst),
    .Wake1(Wake1), .Wake1_Phydst(Wake1_Phydst),
    .Wake2(Wake2), .Wake2_Phydst(Wake2_Phydst),
    .Wake3(Wake3), .Wake3_Phydst(Wake3_Phydst)
  );

  // Status word {Full, Err, Pending_cnt, Wake3..Wake0} and tag word {Wake3_Phydst..Wake0_Phydst}.
  assign st = {Full, Err, Pending_cnt, Wake3, Wake2, Wake1, Wake0};
  assign tv = {Wake3_Phydst, Wake2_Phydst, Wake1_Phydst, Wake0_Phydst};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [5:0] t0, input logic [3:0] l0,
                       input logic v1, input logic [5:0] t1, input logic [3:0] l1);
    Iss0_valid = v0; Iss0_Phydst = t0; Iss0_Lat = l0;
    Iss1_valid = v1; Iss1_Phydst = t1; Iss1_Lat = l1;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 4'd0, 1'b0, 6'd0, 4'd0);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (st !== 11'h000 || tv !== 24'h0) begin
      n_fail++; $display("FAIL reset_held st=%h tv=%h want st=000 tv=000000", st, tv);
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if (st !== 11'h000) begin
      n_fail++; $display("FAIL reset_release st=%h want 000", st);
    end
  endtask

  task automatic test_latency();
    logic [10:0] exp_st;
    logic [23:0] exp_tv;
    drive(1'b1, 6'd12, 4'd3, 1'b0, 6'd0, 4'd0);
    tick();
    idle();
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd1, 4'b0000}) begin
      n_fail++; $display("FAIL lat_issue st=%h want %h", st, {1'b0, 1'b0, 5'd1, 4'b0000});
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_st = {1'b0, 1'b0, (k >= 4) ? 5'd0 : 5'd1, (k == 4) ? 4'b0001 : 4'b0000};
      exp_tv = (k == 4) ? 24'd12 : 24'd0;
      n_chk++;
      if (st !== exp_st || tv !== exp_tv) begin
        n_fail++; $display("FAIL lat_edge%0d st=%h tv=%h want st=%h tv=%h", k, st, tv, exp_st, exp_tv);
      end
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 6'd5, 4'd0, 1'b1, 6'd6, 4'd0);
    tick();
    idle();
`ifdef WAKE_BYPASS_EN
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd0, 4'b0011} || tv !== {6'd0, 6'd0, 6'd6, 6'd5}) begin
      n_fail++; $display("FAIL bypass_wake st=%h tv=%h", st, tv);
    end
`else
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd2, 4'b0000}) begin
      n_fail++; $display("FAIL lat0_table st=%h want %h", st, {1'b0, 1'b0, 5'd2, 4'b0000});
    end
    tick();
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd0, 4'b0011} || tv !== {6'd0, 6'd0, 6'd6, 6'd5}) begin
      n_fail++; $display("FAIL lat0_wake st=%h tv=%h", st, tv);
    end
`endif
    tick();
    n_chk++;
    if (st !== 11'h000 || tv !== 24'h0) begin
      n_fail++; $display("FAIL lat0_clear st=%h tv=%h want 0", st, tv);
    end
  endtask

  task automatic test_contention();
    drive(1'b1, 6'd1, 4'd3, 1'b1, 6'd2, 4'd3); tick();
    drive(1'b1, 6'd3, 4'd2, 1'b1, 6'd4, 4'd2); tick();
    drive(1'b1, 6'd5, 4'd1, 1'b1, 6'd6, 4'd1); tick();
    idle();
    tick();
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd6, 4'b0000}) begin
      n_fail++; $display("FAIL cont_ready st=%h want %h", st, {1'b0, 1'b0, 5'd6, 4'b0000});
    end
    tick();
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd2, 4'b1111} || tv !== {6'd4, 6'd3, 6'd2, 6'd1}) begin
      n_fail++; $display("FAIL cont_first st=%h tv=%h", st, tv);
    end
    tick();
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd0, 4'b0011} || tv !== {6'd0, 6'd0, 6'd6, 6'd5}) begin
      n_fail++; $display("FAIL cont_second st=%h tv=%h", st, tv);
    end
    tick();
    n_chk++;
    if (st !== 11'h000 || tv !== 24'h0) begin
      n_fail++; $display("FAIL cont_idle st=%h tv=%h want 0", st, tv);
    end
  endtask

  task automatic test_tag0();
    drive(1'b1, 6'd0, 4'd2, 1'b1, 6'd7, 4'd2);
    tick();
    idle();
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd1, 4'b0000}) begin
      n_fail++; $display("FAIL tag0_ignored st=%h want %h", st, {1'b0, 1'b0, 5'd1, 4'b0000});
    end
    repeat (2) tick();
    tick();
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd0, 4'b0001} || tv !== 24'd7) begin
      n_fail++; $display("FAIL tag0_wake st=%h tv=%h want wake0 tag 7 only", st, tv);
    end
  endtask

  task automatic test_flush();
    logic quiet;
    drive(1'b1, 6'd1, 4'd2, 1'b1, 6'd2, 4'd10); tick();
    drive(1'b1, 6'd3, 4'd10, 1'b1, 6'd4, 4'd10); tick();
    drive(1'b1, 6'd5, 4'd10, 1'b0, 6'd0, 4'd0); tick();
    idle();
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd5, 4'b0000}) begin
      n_fail++; $display("FAIL flush_pre st=%h want %h", st, {1'b0, 1'b0, 5'd5, 4'b0000});
    end
    flush = 1'b1;
    drive(1'b1, 6'd9, 4'd0, 1'b1, 6'd10, 4'd2);
    tick();
    idle();
    n_chk++;
    if (st !== 11'h000 || tv !== 24'h0) begin
      n_fail++; $display("FAIL flush_clear st=%h tv=%h want 0", st, tv);
    end
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (st !== 11'h000 || tv !== 24'h0) quiet = 1'b0;
    end
    n_chk++;
    if (quiet !== 1'b1) begin
      n_fail++; $display("FAIL flush_quiet last st=%h tv=%h want 0", st, tv);
    end
  endtask

  task automatic test_full_overflow();
    drive(1'b1, 6'd40, 4'd15, 1'b1, 6'd41, 4'd15); tick();
    drive(1'b1, 6'd42, 4'd15, 1'b1, 6'd43, 4'd15); tick();
    drive(1'b1, 6'd44, 4'd15, 1'b1, 6'd45, 4'd15); tick();
    idle();
    n_chk++;
    if (st !== {1'b0, 1'b0, 5'd6, 4'b0000}) begin
      n_fail++; $display("FAIL full_six st=%h want %h", st, {1'b0, 1'b0, 5'd6, 4'b0000});
    end
    drive(1'b1, 6'd46, 4'd15, 1'b0, 6'd0, 4'd0); tick();
    idle();
    n_chk++;
    if (st !== {1'b1, 1'b0, 5'd7, 4'b0000}) begin
      n_fail++; $display("FAIL full_seven st=%h want %h", st, {1'b1, 1'b0, 5'd7, 4'b0000});
    end
    drive(1'b1, 6'd47, 4'd15, 1'b1, 6'd48, 4'd15); tick();
    idle();
    n_chk++;
    if (st !== {1'b1, 1'b1, 5'd8, 4'b0000}) begin
      n_fail++; $display("FAIL overflow st=%h want %h", st, {1'b1, 1'b1, 5'd8, 4'b0000});
    end
    repeat (3) tick();
    n_chk++;
    if (st !== {1'b1, 1'b1, 5'd8, 4'b0000}) begin
      n_fail++; $display("FAIL err_sticky st=%h want %h", st, {1'b1, 1'b1, 5'd8, 4'b0000});
    end
  endtask

  task automatic test_reset_midtraffic();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_chk++;
    if (st !== 11'h000 || tv !== 24'h0) begin
      n_fail++; $display("FAIL async_reset st=%h tv=%h want 0", st, tv);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    n_chk++;
    if (st !== 11'h000 || tv !== 24'h0) begin
      n_fail++; $display("FAIL reset_after_release st=%h tv=%h want 0", st, tv);
    end
  endtask

  task automatic test_slot_reuse();
    drive(1'b1, 6'd20, 4'd3, 1'b1, 6'd21, 4'd15); tick();
    drive(1'b1, 6'd22, 4'd15, 1'b1, 6'd23, 4'd15); tick();
    drive(1'b1, 6'd24, 4'd15, 1'b1, 6'd25, 4'd15); tick();
    drive(1'b1, 6'd26, 4'd15, 1'b0, 6'd0, 4'd0); tick();
    idle();
    n_chk++;
    if (st !== {1'b1, 1'b0, 5'd7, 4'b0000}) begin
      n_fail++; $display("FAIL reuse_fill st=%h want %h", st, {1'b1, 1'b0, 5'd7, 4'b0000});
    end
    drive(1'b1, 6'd27, 4'd15, 1'b0, 6'd0, 4'd0); tick();
    idle();
    n_chk++;
    if (st !== {1'b1, 1'b0, 5'd7, 4'b0001} || tv !== 24'd20) begin
      n_fail++; $display("FAIL reuse_prefree st=%h tv=%h want st=%h tv=20", st, tv, {1'b1, 1'b0, 5'd7, 4'b0001});
    end
    drive(1'b1, 6'd28, 4'd1, 1'b0, 6'd0, 4'd0); tick();
    idle();
    n_chk++;
    if (st !== {1'b1, 1'b0, 5'd8, 4'b0000}) begin
      n_fail++; $display("FAIL reuse_full st=%h want %h", st, {1'b1, 1'b0, 5'd8, 4'b0000});
    end
    tick();
    drive(1'b1, 6'd29, 4'd15, 1'b0, 6'd0, 4'd0); tick();
    idle();
    n_chk++;
    if (st !== {1'b1, 1'b1, 5'd7, 4'b0001} || tv !== 24'd28) begin
      n_fail++; $display("FAIL reuse_nofree st=%h tv=%h want st=%h tv=28", st, tv, {1'b1, 1'b1, 5'd7, 4'b0001});
    end
    repeat (30) tick();
    n_chk++;
    if (st !== {1'b0, 1'b1, 5'd0, 4'b0000}) begin
      n_fail++; $display("FAIL reuse_drain st=%h want %h", st, {1'b0, 1'b1, 5'd0, 4'b0000});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bypass();
    test_contention();
    test_tag0();
    test_flush();
    test_full_overflow();
    test_reset_midtraffic();
    test_slot_reuse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
